// File: rtl/demux_1to16_deser_pkg.sv
// Shared constants and types for the 1:16 serial-to-parallel demux.
package demux_pkg;

    localparam int N     = 16;
    localparam int SEL_W = 4;

    typedef logic [SEL_W-1:0] slot_t;

    localparam slot_t FIRST_SLOT = '0;
    localparam slot_t LAST_SLOT  = slot_t'(N - 1);

endpackage

// File: rtl/demux_1to16_deser_slot_counter.sv
// Slot counter: stands in for the transmitter's select lines.
// A sync clears the count, or lands it on slot 1 when the sync cycle itself
// carries the slot 0 bit. wrap marks an accepted bit in the last slot that
// was not pre-empted by a sync.
module slot_counter
    import demux_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  inc,
    input  logic  clr,
    input  logic  load1,
    output slot_t count,
    output logic  wrap
);

    slot_t r_count;
    logic  w_at_last;

    assign w_at_last = (r_count == LAST_SLOT);
    assign wrap      = inc & w_at_last & ~clr;
    assign count     = r_count;

    // Advance on each accepted bit; sync restarts the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= FIRST_SLOT;
        end else if (clr) begin
            r_count <= load1 ? slot_t'(1) : FIRST_SLOT;
        end else if (inc) begin
            r_count <= w_at_last ? FIRST_SLOT : r_count + slot_t'(1);
        end
    end

endmodule

// File: rtl/demux_1to16_deser.sv
// 1:16 deserializer: collects one bit per slot into a shadow word and
// publishes the completed word with a single-cycle valid pulse.
// Slot 0 is the leftmost bit of the [0:N-1] output word.
module demux_1to16_deser
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [SEL_W-1:0] sel,
    output logic [0:N-1]     q,
    output logic             q_valid,
    output logic             frame_err
);

    slot_t        w_slot;
    slot_t        w_wr_slot;
    logic         w_wrap;
    logic         w_load1;
    logic [0:N-1] r_shadow;
    logic [0:N-1] r_q;
    logic         r_q_valid;
    logic         r_frame_err;

    assign w_load1 = sync & din_valid;

    slot_counter u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (din_valid),
        .clr   (sync),
        .load1 (w_load1),
        .count (w_slot),
        .wrap  (w_wrap)
    );

    // A bit arriving with sync always belongs to slot 0.
    assign w_wr_slot = sync ? FIRST_SLOT : w_slot;

    // Capture bits into the shadow word; the last bit bypasses the shadow
    // so the publish happens on the same edge it arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_q      <= '0;
        end else begin
            if (din_valid) begin
                r_shadow[w_wr_slot] <= din;
            end
            if (w_wrap) begin
                r_q <= {r_shadow[0:N-2], din};
            end
        end
    end

    // Registered single-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q_valid   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_q_valid   <= w_wrap;
            r_frame_err <= sync & (w_slot != FIRST_SLOT);
        end
    end

    assign sel       = w_slot;
    assign q         = r_q;
    assign q_valid   = r_q_valid;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_demux_1to16_deser.sv
// Self-checking bench for demux_1to16_deser with a frame-level reference model.
module tb_demux_1to16_deser;

    logic        clk;
    logic        rst;
    logic        din;
    logic        din_valid;
    logic        sync;
    logic [3:0]  sel;
    logic [0:15] q;
    logic        q_valid;
    logic        frame_err;

    int total = 0;
    int bad   = 0;

    // Reference model: bits of the frame in progress, in arrival order.
    bit          m_buf[$];
    logic [15:0] m_q;
    logic        m_qv;
    logic        m_fe;
    logic [3:0]  m_sel;

    demux_1to16_deser dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .sync      (sync),
        .sel       (sel),
        .q         (q),
        .q_valid   (q_valid),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_buf.delete();
        m_q   = '0;
        m_qv  = 1'b0;
        m_fe  = 1'b0;
        m_sel = '0;
    endtask

    // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic cyc(input logic v, input logic s, input logic d);
        din_valid = v;
        sync      = s;
        din       = d;
        @(posedge clk);
        m_qv = 1'b0;
        m_fe = 1'b0;
        if (s) begin
            if (m_buf.size() != 0) m_fe = 1'b1;
            m_buf.delete();
        end
        if (v) begin
            m_buf.push_back(d);
            if (m_buf.size() == 16) begin
                for (int i = 0; i < 16; i++) m_q[15-i] = m_buf[i];
                m_qv = 1'b1;
                m_buf.delete();
            end
        end
        m_sel = 4'(m_buf.size());
        #1;
        din_valid = 1'b0;
        sync      = 1'b0;
        din       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 0; din_valid = 0; sync = 0;
        model_reset();
        #12;
        total++;
        if (sel !== 4'd0 || q !== 16'h0 || q_valid !== 1'b0 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: sel=%0d q=%h qv=%b fe=%b, want all zero", sel, q, q_valid, frame_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [15:0] w = 16'hACF1;
        int pulses = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, w[15-i]);
            total++;
            if (q_valid !== m_qv || frame_err !== m_fe || sel !== m_sel || q !== m_q) begin
                bad++;
                $display("FAIL single_cycle%0d: sel=%0d q=%h qv=%b fe=%b, want sel=%0d q=%h qv=%b fe=%b",
                         i, sel, q, q_valid, frame_err, m_sel, m_q, m_qv, m_fe);
            end
            if (q_valid) pulses++;
            if (i == 15) begin
                total++;
                if (q_valid !== 1'b1 || q !== 16'hACF1 || sel !== 4'd0) begin
                    bad++;
                    $display("FAIL single_publish: q=%h qv=%b sel=%0d, want q=acf1 qv=1 sel=0", q, q_valid, sel);
                end
            end
        end
        cyc(1'b0, 1'b0, 1'b0);
        total++;
        if (pulses != 1 || q_valid !== 1'b0 || q !== 16'hACF1) begin
            bad++;
            $display("FAIL single_pulse_once: pulses=%0d qv=%b q=%h, want 1 0 acf1", pulses, q_valid, q);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ws = {16'hACF1, 16'hCBE3};
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 1'b0, ws[31-i]);
            total++;
            if (q_valid !== m_qv || frame_err !== m_fe || sel !== m_sel || q !== m_q) begin
                bad++;
                $display("FAIL b2b_cycle%0d: sel=%0d q=%h qv=%b fe=%b, want sel=%0d q=%h qv=%b fe=%b",
                         i, sel, q, q_valid, frame_err, m_sel, m_q, m_qv, m_fe);
            end
            total++;
            if (q_valid !== ((i == 15) || (i == 31))) begin
                bad++;
                $display("FAIL b2b_pulse_timing: after bit %0d qv=%b", i + 1, q_valid);
            end
            if (i > 15 && i < 31) begin
                total++;
                if (q !== 16'hACF1) begin
                    bad++;
                    $display("FAIL b2b_hold_first: q=%h want acf1", q);
                end
            end
        end
        total++;
        if (q !== 16'hCBE3) begin
            bad++;
            $display("FAIL b2b_second_word: q=%h want cbe3", q);
        end
    endtask

    task automatic test_gaps();
        logic [15:0] w = 16'hCBE3;
        int pulses = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, w[15-i]);
            if (q_valid) pulses++;
            total++;
            if (q_valid !== m_qv || frame_err !== m_fe || sel !== m_sel || q !== m_q) begin
                bad++;
                $display("FAIL gaps_bit%0d: sel=%0d q=%h qv=%b fe=%b, want sel=%0d q=%h qv=%b fe=%b",
                         i, sel, q, q_valid, frame_err, m_sel, m_q, m_qv, m_fe);
            end
            if (i == 5 || i == 11) begin
                for (int g = 0; g < 3; g++) begin
                    cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
                    if (q_valid) pulses++;
                    total++;
                    if (sel !== 4'(i + 1) || q_valid !== 1'b0) begin
                        bad++;
                        $display("FAIL gaps_hold: sel=%0d qv=%b, want sel=%0d qv=0", sel, q_valid, i + 1);
                    end
                end
            end
        end
        total++;
        if (pulses != 1 || q !== 16'hCBE3) begin
            bad++;
            $display("FAIL gaps_result: pulses=%0d q=%h, want 1 cbe3", pulses, q);
        end
    endtask

    task automatic test_sync_truncate();
        logic [15:0] w = 16'h1234;
        int errs = 0;
        int pulses = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)));
            if (frame_err) errs++;
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, (i == 0), w[15-i]);
            if (frame_err) errs++;
            if (q_valid) pulses++;
            total++;
            if (q_valid !== m_qv || frame_err !== m_fe || sel !== m_sel || q !== m_q) begin
                bad++;
                $display("FAIL trunc_bit%0d: sel=%0d q=%h qv=%b fe=%b, want sel=%0d q=%h qv=%b fe=%b",
                         i, sel, q, q_valid, frame_err, m_sel, m_q, m_qv, m_fe);
            end
        end
        total++;
        if (errs != 1 || pulses != 1 || q !== 16'h1234) begin
            bad++;
            $display("FAIL trunc_result: errs=%0d pulses=%0d q=%h, want 1 1 1234", errs, pulses, q);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] w = 16'hACF1;
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (sel !== 4'd0 || q !== 16'h0 || q_valid !== 1'b0 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: sel=%0d q=%h qv=%b fe=%b, want all zero", sel, q, q_valid, frame_err);
        end
        model_reset();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, w[15-i]);
            total++;
            if (q_valid !== m_qv || frame_err !== m_fe || sel !== m_sel || q !== m_q) begin
                bad++;
                $display("FAIL post_reset_bit%0d: sel=%0d q=%h qv=%b fe=%b, want sel=%0d q=%h qv=%b fe=%b",
                         i, sel, q, q_valid, frame_err, m_sel, m_q, m_qv, m_fe);
            end
        end
        total++;
        if (q !== 16'hACF1) begin
            bad++;
            $display("FAIL post_reset_word: q=%h want acf1", q);
        end
    endtask

    task automatic test_sync_at_zero();
        logic [15:0] w = 16'h5A3C;
        int errs = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, (i == 0), w[15-i]);
            if (frame_err) errs++;
            total++;
            if (q_valid !== m_qv || frame_err !== m_fe || sel !== m_sel || q !== m_q) begin
                bad++;
                $display("FAIL sync0_bit%0d: sel=%0d q=%h qv=%b fe=%b, want sel=%0d q=%h qv=%b fe=%b",
                         i, sel, q, q_valid, frame_err, m_sel, m_q, m_qv, m_fe);
            end
        end
        total++;
        if (errs != 0 || q !== 16'h5A3C) begin
            bad++;
            $display("FAIL sync0_result: errs=%0d q=%h, want 0 5a3c", errs, q);
        end
    endtask

    task automatic test_sync_at_last();
        int pulses = 0;
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        cyc(1'b1, 1'b1, 1'b1);
        if (q_valid) pulses++;
        total++;
        if (frame_err !== 1'b1 || q_valid !== 1'b0 || sel !== 4'd1 || q !== m_q) begin
            bad++;
            $display("FAIL sync_last: fe=%b qv=%b sel=%0d q=%h, want fe=1 qv=0 sel=1 q=%h",
                     frame_err, q_valid, sel, q, m_q);
        end
        cyc(1'b0, 1'b1, 1'b0);
        total++;
        if (frame_err !== 1'b1 || sel !== 4'd0) begin
            bad++;
            $display("FAIL sync_novalid: fe=%b sel=%0d, want fe=1 sel=0", frame_err, sel);
        end
    endtask

    task automatic test_random();
        int pulses = 0;
        int exp_pulses = 0;
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)));
            if (q_valid) pulses++;
            if (m_qv) exp_pulses++;
            total++;
            if (q_valid !== m_qv || frame_err !== m_fe || sel !== m_sel || q !== m_q) begin
                bad++;
                $display("FAIL random_cycle%0d: sel=%0d q=%h qv=%b fe=%b, want sel=%0d q=%h qv=%b fe=%b",
                         i, sel, q, q_valid, frame_err, m_sel, m_q, m_qv, m_fe);
            end
        end
        total++;
        if (pulses != exp_pulses || exp_pulses == 0) begin
            bad++;
            $display("FAIL random_pulse_count: got %0d want %0d (nonzero)", pulses, exp_pulses);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gaps();
        test_sync_truncate();
        test_async_reset();
        test_sync_at_zero();
        test_sync_at_last();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
